// File: rtl/sram_xbar_pkg.sv
// sram_xbar_pkg: shared types and helpers for the sram_xbar_n crossbar.
//   - read-latency limits and the maximum slave count
//   - sel_entry_t: one stage of the response select pipeline {valid, idx, miss}
//   - lowest_hit(): priority encoder, lowest set bit wins
package sram_xbar_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;
    localparam int MAX_SLAVE  = 16;
    localparam int IDX_W      = 4;

    typedef logic [IDX_W-1:0] slave_idx_t;

    typedef struct packed {
        logic       valid;   // a request entered this stage
        slave_idx_t idx;     // slave that owns the response
        logic       miss;    // request decoded to no slave
    } sel_entry_t;

    // Lowest index wins when regions overlap.
    function automatic slave_idx_t lowest_hit(input logic [MAX_SLAVE-1:0] hit);
        slave_idx_t idx;
        idx = '0;
        for (int i = MAX_SLAVE - 1; i >= 0; i--) begin
            if (hit[i]) idx = slave_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sram_xbar_decode.sv
// sram_xbar_decode: combinational address decoder for sram_xbar_n.
// Ports:
//   addr   in   request address
//   winner out  lowest-index slave whose (addr & mask) == base
//   miss   out  no slave region matched
module sram_xbar_decode
    import sram_xbar_pkg::*;
#(
    parameter int                            LEN_ADDR   = 64,
    parameter int                            N_SLAVE    = 4,
    parameter logic [N_SLAVE*LEN_ADDR-1:0]   SLAVE_BASE = '0,
    parameter logic [N_SLAVE*LEN_ADDR-1:0]   SLAVE_MASK = '0
) (
    input  logic [LEN_ADDR-1:0] addr,
    output slave_idx_t          winner,
    output logic                miss
);

    logic [MAX_SLAVE-1:0] hit;

    always_comb begin
        hit = '0;
        for (int i = 0; i < N_SLAVE; i++) begin
            hit[i] = ((addr & SLAVE_MASK[i*LEN_ADDR +: LEN_ADDR]) ==
                      SLAVE_BASE[i*LEN_ADDR +: LEN_ADDR]);
        end
        winner = lowest_hit(hit);
        miss   = ~|hit;
    end

endmodule

// File: rtl/sram_xbar_n.sv
// sram_xbar_n: one-master, N-slave SRAM-port crossbar.
// The request path is combinational: address/write data are broadcast, and
// only the decoded slave sees its strobe and byte enables. Each accepted
// request pushes {idx, miss} into an RD_LAT-deep select pipeline that steers
// the returning slave data to master_douta; misses return 0 and pulse decerr.
// Optional macro SRAM_XBAR_ERR_CAPTURE_EN enables the sticky unmapped-access
// capture (err_valid/err_addr/err_write); without it those outputs are 0 and
// err_clr is ignored.
// Ports:
//   clk, rst                      clock, async active-high reset
//   master_addra/dina/ena/wea     master request
//   master_douta, decerr          response data and decode-error pulse
//   slave_addra/dina/ena/wea      per-slave request, packed slave i at [i*W +: W]
//   slave_douta                   per-slave read data, same packing
//   err_clr                       clears the captured error
//   err_valid/err_addr/err_write  first unmapped access since last clear
module sram_xbar_n
    import sram_xbar_pkg::*;
#(
    parameter int                            LEN_ADDR   = 64,
    parameter int                            LEN_DATA   = 64,
    parameter int                            N_SLAVE    = 4,
    parameter int                            RD_LAT     = 1,
    parameter logic [N_SLAVE*LEN_ADDR-1:0]   SLAVE_BASE = '0,
    parameter logic [N_SLAVE*LEN_ADDR-1:0]   SLAVE_MASK = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [LEN_ADDR-1:0]            master_addra,
    input  logic [LEN_DATA-1:0]            master_dina,
    input  logic                           master_ena,
    input  logic [LEN_DATA/8-1:0]          master_wea,
    output logic [LEN_DATA-1:0]            master_douta,
    output logic                           decerr,
    output logic [N_SLAVE*LEN_ADDR-1:0]    slave_addra,
    output logic [N_SLAVE*LEN_DATA-1:0]    slave_dina,
    output logic [N_SLAVE-1:0]             slave_ena,
    output logic [N_SLAVE*LEN_DATA/8-1:0]  slave_wea,
    input  logic [N_SLAVE*LEN_DATA-1:0]    slave_douta,
    input  logic                           err_clr,
    output logic                           err_valid,
    output logic [LEN_ADDR-1:0]            err_addr,
    output logic                           err_write
);

    localparam int WE_W = LEN_DATA / 8;
    // Out-of-range latencies are clamped to the supported 1..2.
    localparam int LAT  = (RD_LAT >= RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT_MIN;

    slave_idx_t dec_winner;
    logic       dec_miss;

    sram_xbar_decode #(
        .LEN_ADDR   (LEN_ADDR),
        .N_SLAVE    (N_SLAVE),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .addr   (master_addra),
        .winner (dec_winner),
        .miss   (dec_miss)
    );

    // ---------------- request path ----------------
    assign slave_addra = {N_SLAVE{master_addra}};
    assign slave_dina  = {N_SLAVE{master_dina}};

    always_comb begin
        slave_ena = '0;
        slave_wea = '0;
        for (int i = 0; i < N_SLAVE; i++) begin
            if (!dec_miss && dec_winner == slave_idx_t'(i)) begin
                slave_ena[i]                = master_ena;
                slave_wea[i*WE_W +: WE_W]   = master_wea;
            end
        end
    end

    // ---------------- select pipeline ----------------
    sel_entry_t sel_q [LAT];
    sel_entry_t sel_d [LAT];
    sel_entry_t sel_out;

    // Stage 0 keeps idx/miss while idle so master_douta keeps tracking the
    // held output of the last addressed slave; valid marks only the cycle
    // after a request so decerr is a single pulse. Later stages shift
    // unconditionally to give a fixed latency.
    always_comb begin
        sel_d[0]       = sel_q[0];
        sel_d[0].valid = master_ena;
        if (master_ena) begin
            sel_d[0].idx  = dec_winner;
            sel_d[0].miss = dec_miss;
        end
        for (int s = 1; s < LAT; s++) begin
            sel_d[s] = sel_q[s-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) sel_q[s] <= '0;
        end else begin
            for (int s = 0; s < LAT; s++) sel_q[s] <= sel_d[s];
        end
    end

    assign sel_out = sel_q[LAT-1];
    assign decerr  = sel_out.valid & sel_out.miss;

    always_comb begin
        master_douta = '0;
        if (!sel_out.miss) begin
            for (int i = 0; i < N_SLAVE; i++) begin
                if (sel_out.idx == slave_idx_t'(i)) begin
                    master_douta = slave_douta[i*LEN_DATA +: LEN_DATA];
                end
            end
        end
    end

    // ---------------- error capture ----------------
`ifdef SRAM_XBAR_ERR_CAPTURE_EN
    logic                err_valid_q, err_valid_d;
    logic [LEN_ADDR-1:0] err_addr_q,  err_addr_d;
    logic                err_write_q, err_write_d;
    logic                capture;

    // A clear in the same cycle as a miss frees the slot for that miss.
    assign capture = master_ena & dec_miss & (~err_valid_q | err_clr);

    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        err_write_d = err_write_q;
        if (capture) begin
            err_valid_d = 1'b1;
            err_addr_d  = master_addra;
            err_write_d = |master_wea;
        end else if (err_clr) begin
            err_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_write_q <= 1'b0;
        end else begin
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            err_write_q <= err_write_d;
        end
    end

    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;
    assign err_write = err_write_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_valid      = 1'b0;
    assign err_addr       = '0;
    assign err_write      = 1'b0;
`endif

endmodule

// File: doc/sram_xbar_n.md
# sram_xbar_n

Parametrised one-master, N-slave SRAM-port crossbar with address-decoded slave regions, configurable read latency and decode-error reporting. It sits between the pipeline data port and the SoC's data-side SRAMs and peripheral register blocks. It replaces the fixed two-slave, externally selected crossbar. Unmapped accesses are flagged rather than silently aliased.

## Interface
- LEN_ADDR, 64, address width
- LEN_DATA, 64, data width; multiple of 8
- N_SLAVE, 4, slave count, 1..16
- RD_LAT, 1, slave read latency in cycles, 1 or 2
- SLAVE_BASE, 0, packed N_SLAVE*LEN_ADDR base addresses; slave i at bits [i*LEN_ADDR +: LEN_ADDR]
- SLAVE_MASK, 0, packed N_SLAVE*LEN_ADDR compare masks, same packing
- clk  in  1  clock; the one clock
- rst  in  1  reset, asynchronous, active-high
- master_addra  in  LEN_ADDR  request address
- master_dina  in  LEN_DATA  write data
- master_ena  in  1  request strobe
- master_wea  in  LEN_DATA/8  byte write enables
- master_douta  out  LEN_DATA  read data
- decerr  out  1  decode-error pulse, aligned with master_douta
- slave_addra  out  N_SLAVE*LEN_ADDR  per-slave address
- slave_dina  out  N_SLAVE*LEN_DATA  per-slave write data
- slave_ena  out  N_SLAVE  per-slave strobe
- slave_wea  out  N_SLAVE*LEN_DATA/8  per-slave byte enables
- slave_douta  in  N_SLAVE*LEN_DATA  per-slave read data
- err_clr  in  1  clears captured error
- err_valid  out  1  sticky unmapped-access flag
- err_addr  out  LEN_ADDR  first unmapped address
- err_write  out  1  first unmapped access was a write

## Operation
- Hit: hit[i] = ((master_addra & MASK_i) == BASE_i). Lowest index wins on overlap. Miss means no hit.
- Request path is combinational. addra and dina are broadcast to all slaves.
- slave_ena[i] = master_ena & winner==i. slave_wea[i] = master_wea when slave i is the winner, else 0.
- On a miss, no slave is enabled, writes are dropped, and the read returns 0.
- Every accepted request (master_ena=1), read or write, pushes {idx, miss} into an RD_LAT-deep select pipeline.
- When master_ena=0, pipeline stage 0 holds its value (SRAM hold semantics). master_douta therefore tracks the last selected slave's held output.
- master_douta = miss_out ? 0 : slave_douta[idx_out].
- decerr = 1 for exactly one cycle, RD_LAT cycles after a missed request. Back-to-back misses give back-to-back pulses.
- Reset values: all select stages idx=0, miss=0, valid=0; decerr=0; err_valid=0, err_addr=0, err_write=0. With no access since reset, master_douta = slave_douta[0].
- Reset mid-operation discards in-flight responses. No decerr is emitted for requests issued before reset deassertion.

## Timing
- Request to slave strobe: 0 cycles (combinational).
- Request to master_douta/decerr: RD_LAT cycles.
- Throughput: one request per cycle, no stalls.
- RD_LAT=2: a request at cycle t selects data at t+2 even if a different slave is accessed at t+1.
- Error capture on miss with master_ena=1 and err_valid=0 (or err_clr=1 in the same cycle): next cycle err_valid=1, with addr/write latched.
- err_clr together with a new miss: the new miss is captured.
- err_clr alone: err_valid=0 next cycle.

## Configuration
- SRAM_XBAR_ERR_CAPTURE_EN defined: err_valid/err_addr/err_write capture logic as above.
- Not defined: ports remain, err_valid/err_addr/err_write tied 0, err_clr ignored. decerr is unaffected.

## Structure
- Package sram_xbar_pkg:
  - RD_LAT limits
  - max N_SLAVE
  - typedef for the select-pipeline entry {valid, idx, miss}
  - function for the lowest-index hit encoder
- Sub-module sram_xbar_decode: combinational hit/winner/miss from the address and the base/mask tables. The top holds the select pipeline, output mux and error capture.

## Test plan
Common setup: N_SLAVE=3; base/mask 0x8000_0000/0xF000_0000, 0x6000_0000/0xF000_0000, 0x1000_0000/0xFFFF_F000.
- Read 0x8000_0010, slave0 returns 0xDEAD_BEEF -> slave_ena=3'b001, master_douta=0xDEAD_BEEF at t+RD_LAT, decerr=0.
- Write 0x6000_0008, wea=0xFF -> only slave_wea[1]=0xFF, others 0.
- Alternating reads slave1/slave2 every cycle, RD_LAT=2 -> douta sequence matches each slave's data in order, no bubbles.
- Read 0x2000_0000 -> slave_ena=0, douta=0 and decerr=1 at t+RD_LAT; err_valid=1, err_addr=0x2000_0000, err_write=0. A second miss at 0x3000_0000 leaves err_addr unchanged.
- err_clr plus write miss to 0x4000_0000 in the same cycle -> err_valid stays 1, err_addr=0x4000_0000, err_write=1. Without the macro, all err_* stay 0.
- Assert rst one cycle after a miss read -> decerr never pulses, outputs at reset values.
